sram_port_ctrl: RTL and testbench



---
 rtl/sram_port_ctrl_if.sv | 43 ++++
 rtl/sram_port_ctrl.sv | 159 +++++++++++++++
 tb/tb_sram_port_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_port_ctrl_if                                               |
// | Purpose  : Core-side request/response channels of the SRAM port controller |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sram_port_ctrl_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_WMASKS  = 4,
   parameter int BADDR_WIDTH = 32
);
   logic                   p0_req_valid;
   logic                   p0_req_ready;
   logic                   p0_req_we;
   logic [NUM_WMASKS-1:0]  p0_req_wmask;
   logic [BADDR_WIDTH-1:0] p0_req_addr;
   logic [DATA_WIDTH-1:0]  p0_req_wdata;
   logic                   p0_rsp_valid;
   logic                   p0_rsp_we;
   logic                   p0_rsp_err;
   logic [DATA_WIDTH-1:0]  p0_rsp_rdata;
   logic                   p1_req_valid;
   logic                   p1_req_ready;
   logic [BADDR_WIDTH-1:0] p1_req_addr;
   logic                   p1_rsp_valid;
   logic                   p1_rsp_err;
   logic [DATA_WIDTH-1:0]  p1_rsp_rdata;

   modport master (
      output p0_req_valid, p0_req_we, p0_req_wmask, p0_req_addr, p0_req_wdata,
      output p1_req_valid, p1_req_addr,
      input  p0_req_ready, p0_rsp_valid, p0_rsp_we, p0_rsp_err, p0_rsp_rdata,
      input  p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata
   );

   modport slave (
      input  p0_req_valid, p0_req_we, p0_req_wmask, p0_req_addr, p0_req_wdata,
      input  p1_req_valid, p1_req_addr,
      output p0_req_ready, p0_rsp_valid, p0_rsp_we, p0_rsp_err, p0_rsp_rdata,
      output p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_port_ctrl                                                  |
// | Purpose  : Drives a 1RW+1R SRAM macro from two valid/ready channels with   |
// |            fixed 3-cycle in-order responses and optional zero-fill.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_port_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_WMASKS  = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
   parameter int BADDR_WIDTH = 32,
   parameter int INIT_ZERO   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sram_port_ctrl_if.slave       bus,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1,
   output logic                  init_done
);
   localparam logic [BADDR_WIDTH:0] c_BYTE_LIMIT = (BADDR_WIDTH+1)'(4 * RAM_DEPTH);
   localparam logic [ADDR_WIDTH:0]  c_CNT_LAST   = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]  c_CNT_ONE    = (ADDR_WIDTH+1)'(1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH:0]   r_init_cnt;
   logic                  r_init_done;
   logic                  r_p0_s1_vld, r_p0_s1_we, r_p0_s1_err;
   logic                  r_p0_s2_vld, r_p0_s2_we, r_p0_s2_err;
   logic                  r_p1_s1_vld, r_p1_s1_err;
   logic                  r_p1_s2_vld, r_p1_s2_err;

   logic [ADDR_WIDTH-1:0] w_p0_word, w_p1_word;
   logic                  w_p0_err, w_p1_err;
   logic                  w_p0_fire, w_p1_fire, w_p0_wr_fire, w_collide;

   always_comb begin
      w_p0_word    = bus.p0_req_addr[ADDR_WIDTH+1:2];
      w_p1_word    = bus.p1_req_addr[ADDR_WIDTH+1:2];
      w_p0_err     = (bus.p0_req_addr[1:0] != 2'b00) | ({1'b0, bus.p0_req_addr} >= c_BYTE_LIMIT);
      w_p1_err     = (bus.p1_req_addr[1:0] != 2'b00) | ({1'b0, bus.p1_req_addr} >= c_BYTE_LIMIT);
      w_p0_fire    = bus.p0_req_valid & r_init_done;
      w_p0_wr_fire = w_p0_fire & bus.p0_req_we & ~w_p0_err;
      // A same-cycle read of the word port 0 is writing would see stale data, so hold port 1.
      w_collide    = w_p0_wr_fire & bus.p1_req_valid & ~w_p1_err & (w_p0_word == w_p1_word);
      w_p1_fire    = bus.p1_req_valid & r_init_done & ~w_collide;
   end

   assign bus.p0_req_ready = r_init_done;
   assign bus.p1_req_ready = r_init_done & ~w_collide;
   assign init_done        = r_init_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= ST_INIT;
         r_init_cnt       <= '0;
         r_init_done      <= 1'b0;
         sram_csb0        <= 1'b1;
         sram_web0        <= 1'b1;
         sram_wmask0      <= '0;
         sram_addr0       <= '0;
         sram_din0        <= '0;
         sram_csb1        <= 1'b1;
         sram_addr1       <= '0;
         r_p0_s1_vld      <= 1'b0;
         r_p0_s1_we       <= 1'b0;
         r_p0_s1_err      <= 1'b0;
         r_p0_s2_vld      <= 1'b0;
         r_p0_s2_we       <= 1'b0;
         r_p0_s2_err      <= 1'b0;
         r_p1_s1_vld      <= 1'b0;
         r_p1_s1_err      <= 1'b0;
         r_p1_s2_vld      <= 1'b0;
         r_p1_s2_err      <= 1'b0;
         bus.p0_rsp_valid <= 1'b0;
         bus.p0_rsp_we    <= 1'b0;
         bus.p0_rsp_err   <= 1'b0;
         bus.p0_rsp_rdata <= '0;
         bus.p1_rsp_valid <= 1'b0;
         bus.p1_rsp_err   <= 1'b0;
         bus.p1_rsp_rdata <= '0;
      end else begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_csb1   <= 1'b1;

         case (r_state)
            ST_INIT: begin
               if (INIT_ZERO != 0) begin
                  sram_csb0   <= 1'b0;
                  sram_web0   <= 1'b0;
                  sram_wmask0 <= '1;
                  sram_addr0  <= r_init_cnt[ADDR_WIDTH-1:0];
                  sram_din0   <= '0;
                  r_init_cnt  <= r_init_cnt + c_CNT_ONE;
                  if (r_init_cnt == c_CNT_LAST) begin
                     r_state     <= ST_IDLE;
                     r_init_done <= 1'b1;
                  end
               end else begin
                  r_state     <= ST_IDLE;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               if (w_p0_fire && !w_p0_err) begin
                  sram_csb0  <= 1'b0;
                  sram_web0  <= ~bus.p0_req_we;
                  sram_addr0 <= w_p0_word;
                  if (bus.p0_req_we) begin
                     sram_wmask0 <= bus.p0_req_wmask;
                     sram_din0   <= bus.p0_req_wdata;
                  end
               end
               if (w_p1_fire && !w_p1_err) begin
                  sram_csb1  <= 1'b0;
                  sram_addr1 <= w_p1_word;
               end
            end
         endcase

         r_p0_s1_vld <= w_p0_fire;
         r_p0_s1_we  <= bus.p0_req_we;
         r_p0_s1_err <= w_p0_err;
         r_p0_s2_vld <= r_p0_s1_vld;
         r_p0_s2_we  <= r_p0_s1_we;
         r_p0_s2_err <= r_p0_s1_err;
         r_p1_s1_vld <= w_p1_fire;
         r_p1_s1_err <= w_p1_err;
         r_p1_s2_vld <= r_p1_s1_vld;
         r_p1_s2_err <= r_p1_s1_err;

         // The macro's dout is only valid at this edge, so it is captured here and nowhere else.
         bus.p0_rsp_valid <= r_p0_s2_vld;
         bus.p0_rsp_we    <= r_p0_s2_vld & r_p0_s2_we;
         bus.p0_rsp_err   <= r_p0_s2_vld & r_p0_s2_err;
         bus.p0_rsp_rdata <= (r_p0_s2_vld & ~r_p0_s2_we & ~r_p0_s2_err) ? sram_dout0 : '0;
         bus.p1_rsp_valid <= r_p1_s2_vld;
         bus.p1_rsp_err   <= r_p1_s2_vld & r_p1_s2_err;
         bus.p1_rsp_rdata <= (r_p1_s2_vld & ~r_p1_s2_err) ? sram_dout1 : '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_port_ctrl                                               |
// | Purpose  : Self-checking bench for sram_port_ctrl with a behavioural macro |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_port_ctrl;
   typedef struct {
      logic        we;
      logic        err;
      logic [31:0] rdata;
      int          due;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        sram_csb0, sram_web0, sram_csb1, init_done;
   logic [3:0]  sram_wmask0;
   logic [7:0]  sram_addr0, sram_addr1;
   logic [31:0] sram_din0, sram_dout0, sram_dout1;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          rsp0_cnt = 0, rsp1_cnt = 0;
   logic [31:0] last_p0_rdata, last_p1_rdata;
   logic        last_p0_err, last_p1_err;
   exp_t        q0[$], q1[$];
   logic [31:0] ref_mem [256];
   logic [31:0] mem [256];

   sram_port_ctrl_if #(.DATA_WIDTH(32), .NUM_WMASKS(4), .BADDR_WIDTH(32)) bus ();

   sram_port_ctrl #(
      .DATA_WIDTH(32), .NUM_WMASKS(4), .ADDR_WIDTH(8), .RAM_DEPTH(256),
      .BADDR_WIDTH(32), .INIT_ZERO(1)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
      .init_done(init_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural macro: pins sampled at posedge, dout driven after the next negedge, X after the next posedge.
   logic       m0_en = 1'b0, m0_we = 1'b0, m1_en = 1'b0;
   logic [3:0] m0_mask;
   logic [7:0] m0_addr, m1_addr;
   logic [31:0] m0_din;

   always @(posedge clk) begin
      m0_en      <= !sram_csb0;
      m0_we      <= !sram_web0;
      m0_mask    <= sram_wmask0;
      m0_addr    <= sram_addr0;
      m0_din     <= sram_din0;
      m1_en      <= !sram_csb1;
      m1_addr    <= sram_addr1;
      sram_dout0 <= 'x;
      sram_dout1 <= 'x;
   end

   always @(negedge clk) begin
      if (m0_en && m0_we) begin
         for (int b = 0; b < 4; b++)
            if (m0_mask[b]) mem[m0_addr][8*b +: 8] = m0_din[8*b +: 8];
      end
      if (m0_en && !m0_we) sram_dout0 <= mem[m0_addr];
      if (m1_en) sram_dout1 <= mem[m1_addr];
   end

   // Scoreboard: responses are compared against the queue head, accepts push new expectations.
   always @(negedge clk) begin
      exp_t        e;
      logic [7:0]  w;
      if (bus.p0_rsp_valid) begin
         rsp0_cnt++;
         n_checks++;
         if (q0.size() == 0) begin
            n_errors++;
            $display("FAIL p0_unexpected_rsp: got rdata=%h at cyc %0d, required no response", bus.p0_rsp_rdata, cyc);
         end else begin
            e = q0.pop_front();
            if (bus.p0_rsp_we !== e.we || bus.p0_rsp_err !== e.err || bus.p0_rsp_rdata !== e.rdata || cyc != e.due) begin
               n_errors++;
               $display("FAIL p0_rsp: got we=%0b err=%0b rdata=%h cyc=%0d, required we=%0b err=%0b rdata=%h cyc=%0d",
                        bus.p0_rsp_we, bus.p0_rsp_err, bus.p0_rsp_rdata, cyc, e.we, e.err, e.rdata, e.due);
            end
         end
         last_p0_rdata = bus.p0_rsp_rdata;
         last_p0_err   = bus.p0_rsp_err;
      end
      if (bus.p1_rsp_valid) begin
         rsp1_cnt++;
         n_checks++;
         if (q1.size() == 0) begin
            n_errors++;
            $display("FAIL p1_unexpected_rsp: got rdata=%h at cyc %0d, required no response", bus.p1_rsp_rdata, cyc);
         end else begin
            e = q1.pop_front();
            if (bus.p1_rsp_err !== e.err || bus.p1_rsp_rdata !== e.rdata || cyc != e.due) begin
               n_errors++;
               $display("FAIL p1_rsp: got err=%0b rdata=%h cyc=%0d, required err=%0b rdata=%h cyc=%0d",
                        bus.p1_rsp_err, bus.p1_rsp_rdata, cyc, e.err, e.rdata, e.due);
            end
         end
         last_p1_rdata = bus.p1_rsp_rdata;
         last_p1_err   = bus.p1_rsp_err;
      end
      if (!reset && bus.p0_req_valid && bus.p0_req_ready) begin
         e.we    = bus.p0_req_we;
         e.err   = (bus.p0_req_addr[1:0] != 2'b00) || (bus.p0_req_addr >= 32'h400);
         e.due   = cyc + 3;
         e.rdata = 32'h0;
         if (!e.err) begin
            w = bus.p0_req_addr[9:2];
            if (e.we) begin
               for (int b = 0; b < 4; b++)
                  if (bus.p0_req_wmask[b]) ref_mem[w][8*b +: 8] = bus.p0_req_wdata[8*b +: 8];
            end else begin
               e.rdata = ref_mem[w];
            end
         end
         q0.push_back(e);
      end
      if (!reset && bus.p1_req_valid && bus.p1_req_ready) begin
         e.we    = 1'b0;
         e.err   = (bus.p1_req_addr[1:0] != 2'b00) || (bus.p1_req_addr >= 32'h400);
         e.due   = cyc + 3;
         e.rdata = e.err ? 32'h0 : ref_mem[bus.p1_req_addr[9:2]];
         q1.push_back(e);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents requests and holds each until accepted; returns #1 after the last accepting edge.
   task automatic send(input logic v0, input logic we, input logic [3:0] m, input logic [31:0] a0,
                       input logic [31:0] d0, input logic v1, input logic [31:0] a1);
      logic pend0, pend1;
      int   guard;
      pend0 = v0;
      pend1 = v1;
      bus.p0_req_valid = v0; bus.p0_req_we = we; bus.p0_req_wmask = m;
      bus.p0_req_addr  = a0; bus.p0_req_wdata = d0;
      bus.p1_req_valid = v1; bus.p1_req_addr = a1;
      guard = 0;
      while ((pend0 || pend1) && guard < 20) begin
         @(negedge clk);
         if (bus.p0_req_ready) pend0 = 1'b0;
         if (bus.p1_req_ready) pend1 = 1'b0;
         @(posedge clk);
         #1;
         if (!pend0) bus.p0_req_valid = 1'b0;
         if (!pend1) bus.p1_req_valid = 1'b0;
         guard++;
      end
      if (pend0 || pend1) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: pending p0=%0b p1=%0b after %0d cycles, required accept", pend0, pend1, guard);
         bus.p0_req_valid = 1'b0;
         bus.p1_req_valid = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(3);
      n_checks++;
      if ({sram_csb0, sram_web0, sram_csb1, sram_wmask0, sram_addr0, sram_addr1, sram_din0} !== {3'b111, 4'h0, 8'h0, 8'h0, 32'h0}) begin
         n_errors++;
         $display("FAIL reset_pins: got csb0=%0b web0=%0b csb1=%0b wmask0=%h addr0=%h addr1=%h din0=%h, required 1 1 1 0 0 0 0",
                  sram_csb0, sram_web0, sram_csb1, sram_wmask0, sram_addr0, sram_addr1, sram_din0);
      end
      n_checks++;
      if ({bus.p0_rsp_valid, bus.p0_rsp_we, bus.p0_rsp_err, bus.p1_rsp_valid, bus.p1_rsp_err, bus.p0_rsp_rdata, bus.p1_rsp_rdata} !== 69'h0) begin
         n_errors++;
         $display("FAIL reset_rsp: got p0 v/we/err=%0b%0b%0b rdata=%h p1 v/err=%0b%0b rdata=%h, required all 0",
                  bus.p0_rsp_valid, bus.p0_rsp_we, bus.p0_rsp_err, bus.p0_rsp_rdata, bus.p1_rsp_valid, bus.p1_rsp_err, bus.p1_rsp_rdata);
      end
      n_checks++;
      if ({init_done, bus.p0_req_ready, bus.p1_req_ready} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_ctrl: got init_done=%0b p0_ready=%0b p1_ready=%0b, required 0 0 0",
                  init_done, bus.p0_req_ready, bus.p1_req_ready);
      end
   endtask

   task automatic test_init;
      int edges, ready_bad;
      reset = 1'b0;
      edges = 0;
      ready_bad = 0;
      while (init_done !== 1'b1 && edges < 400) begin
         if (bus.p0_req_ready !== 1'b0 || bus.p1_req_ready !== 1'b0) ready_bad++;
         @(posedge clk);
         #1;
         edges++;
      end
      n_checks++;
      if (edges != 256) begin
         n_errors++;
         $display("FAIL init_edges: got %0d edges to init_done, required 256", edges);
      end
      n_checks++;
      if (ready_bad != 0) begin
         n_errors++;
         $display("FAIL init_ready: got ready high in %0d init cycles, required 0", ready_bad);
      end
      send(1'b1, 1'b0, 4'h0, 32'h3FC, 32'h0, 1'b0, 32'h0);
      idle(5);
      n_checks++;
      if (last_p0_rdata !== 32'h0 || last_p0_err !== 1'b0) begin
         n_errors++;
         $display("FAIL init_zero_read: got rdata=%h err=%0b, required 00000000 0", last_p0_rdata, last_p0_err);
      end
   endtask

   task automatic test_write_read;
      send(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      send(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 32'h10);
      idle(5);
      n_checks++;
      if (last_p0_rdata !== 32'hDEADBEEF || last_p1_rdata !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL write_read: got p0=%h p1=%h, required deadbeef deadbeef", last_p0_rdata, last_p1_rdata);
      end
   endtask

   task automatic test_byte_mask;
      send(1'b1, 1'b1, 4'b0101, 32'h10, 32'h11223344, 1'b0, 32'h0);
      send(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0);
      send(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 32'h0);
      idle(5);
      n_checks++;
      if (last_p0_rdata !== 32'hDE22BE44) begin
         n_errors++;
         $display("FAIL byte_mask: got %h, required de22be44", last_p0_rdata);
      end
   endtask

   task automatic test_collision;
      bus.p0_req_valid = 1'b1; bus.p0_req_we = 1'b1; bus.p0_req_wmask = 4'hF;
      bus.p0_req_addr  = 32'h14; bus.p0_req_wdata = 32'hCAFEF00D;
      bus.p1_req_valid = 1'b1; bus.p1_req_addr = 32'h14;
      @(negedge clk);
      n_checks++;
      if (bus.p0_req_ready !== 1'b1 || bus.p1_req_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL collision_block: got p0_ready=%0b p1_ready=%0b, required 1 0", bus.p0_req_ready, bus.p1_req_ready);
      end
      @(posedge clk);
      #1;
      bus.p0_req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.p1_req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL collision_retry: got p1_ready=%0b, required 1", bus.p1_req_ready);
      end
      @(posedge clk);
      #1;
      bus.p1_req_valid = 1'b0;
      idle(5);
      n_checks++;
      if (last_p1_rdata !== 32'hCAFEF00D) begin
         n_errors++;
         $display("FAIL collision_data: got %h, required cafef00d", last_p1_rdata);
      end
   endtask

   task automatic test_errors;
      int csb_bad;
      csb_bad = 0;
      send(1'b1, 1'b0, 4'h0, 32'h06, 32'h0, 1'b1, 32'h400);
      repeat (5) begin
         if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) csb_bad++;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (csb_bad != 0) begin
         n_errors++;
         $display("FAIL err_csb: got chip select low in %0d cycles, required 0", csb_bad);
      end
      n_checks++;
      if (last_p0_err !== 1'b1 || last_p1_err !== 1'b1 || last_p0_rdata !== 32'h0 || last_p1_rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL err_rsp: got p0 err=%0b rdata=%h p1 err=%0b rdata=%h, required 1 0 1 0",
                  last_p0_err, last_p0_rdata, last_p1_err, last_p1_rdata);
      end
   endtask

   task automatic test_back_to_back;
      int base;
      base = rsp1_cnt;
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'(4 * i));
      idle(6);
      n_checks++;
      if (rsp1_cnt - base != 4) begin
         n_errors++;
         $display("FAIL b2b_count: got %0d responses, required 4", rsp1_cnt - base);
      end
      base = rsp1_cnt;
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'(16 + 4 * i));
      reset = 1'b1;
      idle(1);
      q0.delete();
      q1.delete();
      n_checks++;
      if (rsp1_cnt - base != 2) begin
         n_errors++;
         $display("FAIL reset_pre_count: got %0d responses before reset, required 2", rsp1_cnt - base);
      end
      base = rsp1_cnt;
      test_reset();
      reset = 1'b0;
      idle(20);
      n_checks++;
      if (rsp1_cnt != base || rsp0_cnt < 0) begin
         n_errors++;
         $display("FAIL reset_flush: got %0d responses after reset, required 0", rsp1_cnt - base);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.p0_req_valid = 1'b0; bus.p0_req_we = 1'b0; bus.p0_req_wmask = 4'h0;
      bus.p0_req_addr  = 32'h0; bus.p0_req_wdata = 32'h0;
      bus.p1_req_valid = 1'b0; bus.p1_req_addr = 32'h0;
      last_p0_rdata = 32'h0; last_p1_rdata = 32'h0;
      last_p0_err = 1'b0; last_p1_err = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom | 32'h1;
         ref_mem[i] = 32'h0;
      end
      #1;
      test_reset();
      test_init();
      test_write_read();
      test_byte_mask();
      test_collision();
      test_errors();
      test_back_to_back();
      n_checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_errors++;
         $display("FAIL pending_rsp: got %0d/%0d outstanding, required 0/0", q0.size(), q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
